// File: rtl/block_zigzag.sv
// block_zigzag: buffers one 8x8 coefficient block (8 row packets) and re-emits it as 8 packets in JPEG zigzag order.
// Latency: o_valid rises one cycle after the edge that accepts row 7 (read side idle); then 1 packet/cycle.
// Backpressure: two ping-pong banks; o_ready drops only when both banks hold a full block; o_data held while !i_ready.
//
// Ports:
//   clk, rstn          clock (posedge) and synchronous active-low reset
//   i_data/i_valid     row packet in {data, pck_no, y, x}; accepted when i_valid && o_ready
//   o_ready            a bank is free to receive rows
//   o_data/o_valid     zigzag-ordered packet out, same layout as i_data
//   i_ready            downstream accepts o_data when o_valid && i_ready
module block_zigzag #(
  parameter int data_width  = 256,
  parameter int total_width = 274,
  parameter int x_size      = 2,
  parameter int y_size      = 2,
  parameter int pck_num     = 14
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [total_width-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [total_width-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_ready
);

  localparam int COEF_W  = data_width / 8;
  localparam int HDR_W   = x_size + y_size + pck_num;
  localparam int Y_LSB   = x_size;
  localparam int PCK_LSB = x_size + y_size;

  // Zigzag scan: output position p takes natural-order coefficient ZZ[p].
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Coefficient storage, indexed [bank][natural index 8*row+col].
  logic [COEF_W-1:0]  mem_q       [2][64];
  // Per-bank header captured from row 0.
  logic [x_size-1:0]  hdr_x_q     [2];
  logic [y_size-1:0]  hdr_y_q     [2];
  logic [pck_num-1:0] hdr_pck_q   [2];

  logic [1:0]             full_q, full_d;
  logic                   wr_bank_q, wr_bank_d;
  logic [2:0]             row_q, row_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [2:0]             k_q, k_d;         // next output packet to load from rd bank
  logic                   ready_q, ready_d;
  logic                   valid_q, valid_d;
  logic [total_width-1:0] data_q, data_d;

  logic accept;
  logic load;

  assign accept = i_valid && ready_q;
  // The output register refills whenever it is empty or being consumed and
  // the read bank holds a complete block.
  assign load   = full_q[rd_bank_q] && (!valid_q || i_ready);

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    row_d     = row_q;
    rd_bank_d = rd_bank_q;
    k_d       = k_q;
    valid_d   = valid_q && !i_ready;
    data_d    = data_q;

    if (accept) begin
      row_d = row_q + 3'd1;
      if (row_q == 3'd7) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    if (load) begin
      valid_d = 1'b1;
      for (int j = 0; j < 8; j++) begin
        data_d[total_width-1-j*COEF_W -: COEF_W] = mem_q[rd_bank_q][ZZ[{k_q, 3'(j)}]];
      end
      data_d[x_size-1:0]          = hdr_x_q[rd_bank_q];
      data_d[Y_LSB +: y_size]     = hdr_y_q[rd_bank_q];
      data_d[PCK_LSB +: pck_num]  = hdr_pck_q[rd_bank_q] + pck_num'(k_q);
      // Once packet 7 sits in the output register the bank contents are no
      // longer needed, so it is released right away. This keeps the write
      // side from stalling during sustained ping-pong streaming.
      if (k_q == 3'd7) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        k_d               = 3'd0;
      end else begin
        k_d = k_q + 3'd1;
      end
    end

    // Write bank and read bank always differ when both updates happen, so
    // the set and the clear above never target the same flag.
    ready_d = !full_d[wr_bank_d];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      row_q     <= 3'd0;
      rd_bank_q <= 1'b0;
      k_q       <= 3'd0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      row_q     <= row_d;
      rd_bank_q <= rd_bank_d;
      k_q       <= k_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
    end
  end

  // Payload storage needs no reset: the full flags alone decide what is live.
  always_ff @(posedge clk) begin
    if (rstn && accept) begin
      for (int c = 0; c < 8; c++) begin
        mem_q[wr_bank_q][{row_q, 3'(c)}] <= i_data[HDR_W+data_width-1-c*COEF_W -: COEF_W];
      end
      if (row_q == 3'd0) begin
        hdr_x_q[wr_bank_q]   <= i_data[x_size-1:0];
        hdr_y_q[wr_bank_q]   <= i_data[Y_LSB +: y_size];
        hdr_pck_q[wr_bank_q] <= i_data[PCK_LSB +: pck_num];
      end
    end
  end

endmodule

// File: tb/tb_block_zigzag.sv
// tb_block_zigzag: randomized stimulus for block_zigzag checked against a packet-level reference model.
// Latency: n/a (testbench).
// Backpressure: i_ready driven randomly or held per phase.
module tb_block_zigzag;

  localparam int DW = 256;
  localparam int TW = 274;
  localparam int XS = 2;
  localparam int YS = 2;
  localparam int PN = 14;
  localparam int CW = DW / 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [TW-1:0] i_data;
  logic          i_valid;
  logic          o_ready;
  logic [TW-1:0] o_data;
  logic          o_valid;
  logic          i_ready;

  always #5 clk = ~clk;

  block_zigzag #(
    .data_width(DW), .total_width(TW), .x_size(XS), .y_size(YS), .pck_num(PN)
  ) dut (
    .clk(clk), .rstn(rstn), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  int zz[64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef struct {
    logic [TW-1:0] dat;
    int            done;  // cycle on which the block became complete
    int            k;
    int            blk;
  } exp_t;

  exp_t          expq[$];
  logic [TW-1:0] stim[$];
  logic [TW-1:0] hs_log[$];
  logic [TW-1:0] rows[8];
  int            nrow = 0;
  int            cyc = 0;
  int            occ = 0;
  int            blk_cnt = 0;
  int            last_freed = 0;
  bit            in_rst = 1'b1;
  bit            exp_valid = 1'b0;
  bit            exp_ready = 1'b0;
  int            valid_pct = 100;
  int            ready_pct = 100;

  function automatic logic [CW-1:0] coef_of(input logic [TW-1:0] p, input int c);
    return p[TW-1-c*CW -: CW];
  endfunction

  function automatic logic [PN-1:0] pck_of(input logic [TW-1:0] p);
    return p[XS+YS +: PN];
  endfunction

  // A complete block in rows[] becomes eight expected output packets.
  task automatic model_block();
    logic [DW-1:0] d;
    logic [PN-1:0] pk;
    blk_cnt++;
    occ++;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) begin
        int n;
        n = zz[8*k+j];
        d[DW-1-j*CW -: CW] = coef_of(rows[n/8], n%8);
      end
      pk = pck_of(rows[0]) + PN'(k);
      expq.push_back('{dat: {d, pk, rows[0][XS +: YS], rows[0][XS-1:0]}, done: cyc, k: k, blk: blk_cnt});
    end
  endtask

  task automatic push_block(input logic [PN-1:0] pck, input logic [YS-1:0] y, input logic [XS-1:0] x,
                            input bit natural);
    logic [DW-1:0] d;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++)
        d[DW-1-c*CW -: CW] = natural ? CW'(8*r+c) : CW'($urandom);
      if (r == 0) stim.push_back({d, pck, y, x});
      else        stim.push_back({d, PN'($urandom), YS'($urandom), XS'($urandom)});
    end
  endtask

  // One clock: decide handshakes from the model, advance the model at the
  // edge, then compare the DUT at the falling edge and drive new inputs.
  task automatic tick();
    bit r, acc, hs;
    r   = rstn;
    acc = r && i_valid && exp_ready;
    hs  = r && exp_valid && i_ready;
    if (hs) hs_log.push_back(o_data);
    @(posedge clk);
    cyc++;
    if (!r) begin
      in_rst = 1'b1;
      expq.delete();
      nrow = 0;
      occ = 0;
      last_freed = blk_cnt;
    end else begin
      in_rst = 1'b0;
      if (hs) void'(expq.pop_front());
      if (acc) begin
        rows[nrow] = stim.pop_front();
        nrow++;
        if (nrow == 8) begin
          model_block();
          nrow = 0;
        end
      end
    end
    exp_valid = !in_rst && expq.size() > 0 && expq[0].done < cyc;
    if (exp_valid && expq[0].k == 7 && expq[0].blk > last_freed) begin
      occ--;
      last_freed = expq[0].blk;
    end
    exp_ready = !in_rst && occ < 2;
    @(negedge clk);
    chk("o_valid", TW'(o_valid), TW'(exp_valid));
    chk("o_ready", TW'(o_ready), TW'(exp_ready));
    if (exp_valid)   chk("o_data", o_data, expq[0].dat);
    else if (in_rst) chk("rst_o_data", o_data, '0);
    i_valid = stim.size() > 0 && int'($urandom % 100) < valid_pct;
    i_data  = i_valid ? stim[0] : {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                                   $urandom, $urandom, $urandom};
    i_ready = int'($urandom % 100) < ready_pct;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((stim.size() > 0 || expq.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) chk("drain_timeout", TW'(stim.size() + expq.size()), '0);
  endtask

  int p0[8] = '{0, 1, 8, 16, 9, 2, 3, 10};
  int p7[8] = '{53, 60, 61, 54, 47, 55, 62, 63};

  initial begin
    logic [TW-1:0] t;
    rstn = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;

    // Reset held with a valid row waiting: nothing may be accepted.
    valid_pct = 100; ready_pct = 100;
    push_block(PN'(1), 2'd0, 2'd0, 1'b0);
    repeat (5) tick();
    stim.delete();
    rstn = 1'b1; i_valid = 1'b0;
    tick();
    chk("rel_ready", TW'(o_ready), TW'(1));

    // Single block with coefficients equal to their natural index.
    hs_log.delete();
    push_block(PN'(5), 2'd2, 2'd1, 1'b1);
    drain(200);
    chk("t2_count", TW'(hs_log.size()), TW'(8));
    if (hs_log.size() >= 8) begin
      t = hs_log[0];
      for (int j = 0; j < 8; j++) chk("t2_p0_coef", TW'(coef_of(t, j)), TW'(p0[j]));
      chk("t2_p0_pck", TW'(pck_of(t)), TW'(5));
      chk("t2_p0_yx", TW'(t[3:0]), TW'(4'b1001));
      t = hs_log[7];
      for (int j = 0; j < 8; j++) chk("t2_p7_coef", TW'(coef_of(t, j)), TW'(p7[j]));
      chk("t2_p7_pck", TW'(pck_of(t)), TW'(12));
      chk("t2_p7_yx", TW'(t[3:0]), TW'(4'b1001));
    end

    // Four back-to-back blocks at full rate.
    for (int b = 0; b < 4; b++) push_block(PN'($urandom), YS'($urandom), XS'($urandom), 1'b0);
    drain(400);

    // Output stalled: two blocks fill both banks and the 17th row is held off.
    ready_pct = 0;
    for (int b = 0; b < 3; b++) push_block(PN'($urandom), YS'($urandom), XS'($urandom), 1'b0);
    repeat (40) tick();
    chk("bp_ready_low", TW'(o_ready), TW'(0));
    chk("bp_valid_held", TW'(o_valid), TW'(1));
    ready_pct = 100;
    drain(400);
    chk("bp_ready_back", TW'(o_ready), TW'(1));

    // Packet number wraps modulo 2^14.
    hs_log.delete();
    push_block(PN'(16382), 2'd3, 2'd2, 1'b0);
    drain(200);
    chk("wrap_count", TW'(hs_log.size()), TW'(8));
    if (hs_log.size() >= 8) begin
      chk("wrap_p0", TW'(pck_of(hs_log[0])), TW'(16382));
      chk("wrap_p1", TW'(pck_of(hs_log[1])), TW'(16383));
      chk("wrap_p2", TW'(pck_of(hs_log[2])), TW'(0));
      chk("wrap_p7", TW'(pck_of(hs_log[7])), TW'(5));
    end

    // Reset after three rows of a block discards them.
    push_block(PN'($urandom), YS'($urandom), XS'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) void'(stim.pop_back());
    for (int n = 0; n < 20 && stim.size() > 0; n++) tick();
    chk("partial_rows_sent", TW'(stim.size()), '0);
    rstn = 1'b0; i_valid = 1'b0;
    repeat (2) tick();
    rstn = 1'b1; i_valid = 1'b0;
    stim.delete();
    tick();
    hs_log.delete();
    push_block(PN'(100), 2'd1, 2'd3, 1'b1);
    drain(200);
    chk("after_rst_count", TW'(hs_log.size()), TW'(8));
    if (hs_log.size() >= 8) begin
      for (int j = 0; j < 8; j++) chk("after_rst_p0", TW'(coef_of(hs_log[0], j)), TW'(p0[j]));
    end

    // Random valid/ready mix.
    valid_pct = 60; ready_pct = 50;
    for (int b = 0; b < 6; b++) push_block(PN'($urandom), YS'($urandom), XS'($urandom), 1'b0);
    drain(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
